// File: rtl/mem_host_bridge.sv
// mem_host_bridge: converts one 512-bit cache line transaction into eight
// 64-bit host-bus beats. A read (fill) issues one burst request and assembles
// the returned beats. A write (evict) issues eight individually granted beats.
// Only one line transaction is in flight at a time.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   op_host[1:0]               00 idle, 01 line read, 10 line write, 11 ignored
//   AddrOut_host[31:0]         line address (offset bits [5:0] dropped)
//   DataOut_host[511:0]        write line, beat i = bits [64i+63:64i]
//   DataIn_host[511:0]         assembled read line, holds the last fill
//   rd_valid_host              one-cycle pulse when a fill completes
//   tx_done_host               one-cycle pulse when any transaction completes
//   bus_req, bus_wr            host bus request, 1 = write beat / 0 = read burst
//   bus_addr[31:0]             bus address
//   bus_wdata[63:0]            write beat data
//   bus_gnt                    host accepts the current request/beat
//   bus_rvalid, bus_rdata      read beat return
module mem_host_bridge (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   op_host,
  input  logic [31:0]  AddrOut_host,
  input  logic [511:0] DataOut_host,
  output logic [511:0] DataIn_host,
  output logic         rd_valid_host,
  output logic         tx_done_host,
  output logic         bus_req,
  output logic         bus_wr,
  output logic [31:0]  bus_addr,
  output logic [63:0]  bus_wdata,
  input  logic         bus_gnt,
  input  logic         bus_rvalid,
  input  logic [63:0]  bus_rdata
);

  localparam int unsigned LINE_W = 512;
  localparam int unsigned BUS_W  = 64;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BEATS  = LINE_W / BUS_W;
  localparam logic [2:0]  LAST_BEAT = 3'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_BEATS,
    WR_BEATS,
    DONE
  } state_t;

  state_t              state;
  logic [2:0]          beat_cnt;
  logic [ADDR_W-1:0]   line_addr;
  logic [LINE_W-1:0]   wline;

  // Index of the beat that follows the current one (used to pre-load outputs)
  logic [2:0]          beat_nxt;
  assign beat_nxt = beat_cnt + 3'd1;

  // Control FSM; every output is loaded together with the state it belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      beat_cnt      <= 3'd0;
      line_addr     <= '0;
      wline         <= '0;
      DataIn_host   <= '0;
      rd_valid_host <= 1'b0;
      tx_done_host  <= 1'b0;
      bus_req       <= 1'b0;
      bus_wr        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_host == 2'b01) begin
            state     <= RD_REQ;
            line_addr <= AddrOut_host & LINE_MASK;
            bus_req   <= 1'b1;
            bus_wr    <= 1'b0;
            bus_addr  <= AddrOut_host & LINE_MASK;
          end else if (op_host == 2'b10) begin
            state     <= WR_BEATS;
            beat_cnt  <= 3'd0;
            line_addr <= AddrOut_host & LINE_MASK;
            wline     <= DataOut_host;
            bus_req   <= 1'b1;
            bus_wr    <= 1'b1;
            bus_addr  <= AddrOut_host & LINE_MASK;
            bus_wdata <= DataOut_host[BUS_W-1:0];
          end
        end

        RD_REQ: begin
          if (bus_gnt) begin
            state    <= RD_BEATS;
            beat_cnt <= 3'd0;
            bus_req  <= 1'b0;
            bus_addr <= '0;
          end
        end

        RD_BEATS: begin
          if (bus_rvalid) begin
            DataIn_host[{beat_cnt, 6'd0} +: BUS_W] <= bus_rdata;
            beat_cnt <= beat_nxt;
            if (beat_cnt == LAST_BEAT) begin
              state         <= DONE;
              tx_done_host  <= 1'b1;
              rd_valid_host <= 1'b1;
            end
          end
        end

        WR_BEATS: begin
          if (bus_gnt) begin
            beat_cnt <= beat_nxt;
            if (beat_cnt == LAST_BEAT) begin
              state        <= DONE;
              tx_done_host <= 1'b1;
              bus_req      <= 1'b0;
              bus_wr       <= 1'b0;
              bus_addr     <= '0;
              bus_wdata    <= '0;
            end else begin
              bus_addr  <= line_addr + {26'd0, beat_nxt, 3'd0};
              bus_wdata <= wline[{beat_nxt, 6'd0} +: BUS_W];
            end
          end
        end

        DONE: begin
          state         <= IDLE;
          tx_done_host  <= 1'b0;
          rd_valid_host <= 1'b0;
        end

        default: begin
          state         <= IDLE;
          beat_cnt      <= 3'd0;
          rd_valid_host <= 1'b0;
          tx_done_host  <= 1'b0;
          bus_req       <= 1'b0;
          bus_wr        <= 1'b0;
          bus_addr      <= '0;
          bus_wdata     <= '0;
        end
      endcase
    end
  end

endmodule
